// File: rtl/fdt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// fdt_tx_scheduler
//
// Purpose:
//   Decides when a PICC response frame may start on the frame-delay-time (FDT)
//   grid. The block follows the PCD frame (pause -> RX -> end of frame) and
//   waits for the minimum-FDT trigger from the fdt block. At that trigger the
//   response can start immediately, or it can be abandoned if it was restricted
//   to the first slot. Otherwise it is offered in up to MAX_SLOTS additional
//   slots, each SLOT_TICKS carrier ticks long. A new PCD pause while a response
//   is still pending abandons that response.
//
//   The trigger-to-tx_start latency is fixed at one cycle. The fdt block's
//   TIMING_ADJUST value has to absorb this cycle at integration.
//
// Handshake:
//   tx_req is a level. The producer holds it until the scheduler answers with
//   exactly one tx_start or one tx_missed pulse. The two pulses never occur in
//   the same cycle. tx_done ends the TX state, and there is no timeout.
//
// Ports:
//   clk                  i  carrier-derived clock, rising edge
//   rst_n                i  synchronous active-low reset
//   pause_n_synchronised i  PCD pause, low during a pause
//   rx_eoc               i  pulse, valid end of PCD frame
//   rx_error             i  pulse, PCD frame decode error
//   fdt_trigger          i  pulse, minimum FDT point reached
//   tx_req               i  level, response data ready
//   tx_fixed_fdt         i  level, response allowed only in the first FDT slot
//   tx_done              i  pulse, transmitter finished the frame
//   tx_start             o  pulse, start transmission now
//   tx_missed            o  pulse, pending response abandoned
//   busy                 o  high in every state except IDLE
//   slot_num             o  current additional slot index, 0 outside SLOT
//   fsm_state            o  debug view of the FSM state encoding
// -----------------------------------------------------------------------------
module fdt_tx_scheduler #(
   parameter int SLOT_TICKS = 128,
   parameter int MAX_SLOTS  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           pause_n_synchronised,
   input  logic                           rx_eoc,
   input  logic                           rx_error,
   input  logic                           fdt_trigger,
   input  logic                           tx_req,
   input  logic                           tx_fixed_fdt,
   input  logic                           tx_done,
   output logic                           tx_start,
   output logic                           tx_missed,
   output logic                           busy,
   output logic [$clog2(MAX_SLOTS+1)-1:0] slot_num,
   output logic [2:0]                     fsm_state
);

   localparam int TW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
   localparam int SW = $clog2(MAX_SLOTS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(SLOT_TICKS - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(MAX_SLOTS);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RX       = 3'd1,
      WAIT_FDT = 3'd2,
      SLOT     = 3'd3,
      TX       = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          start_q, start_d;
   logic          missed_q, missed_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         slot_q   <= '0;
         start_q  <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         slot_q   <= slot_d;
         start_q  <= start_d;
         missed_q <= missed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      slot_d   = slot_q;
      start_d  = 1'b0;
      missed_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!pause_n_synchronised) begin
               state_d = RX;
            end
         end

         RX: begin
            // A decode error discards the frame even when end-of-frame
            // arrives in the same cycle.
            if (rx_error) begin
               state_d = IDLE;
            end else if (rx_eoc) begin
               state_d = WAIT_FDT;
            end
         end

         WAIT_FDT: begin
            // A new PCD pause means the PCD has already moved on. Responding
            // at the trigger would then collide with the next PCD frame.
            if (!pause_n_synchronised) begin
               state_d = RX;
            end else if (fdt_trigger) begin
               if (tx_req) begin
                  start_d = 1'b1;
                  state_d = TX;
               end else if (tx_fixed_fdt) begin
                  missed_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = SLOT;
                  tick_d  = '0;
                  slot_d  = SW'(1);
               end
            end
         end

         SLOT: begin
            if (!pause_n_synchronised) begin
               missed_d = 1'b1;
               state_d  = RX;
               tick_d   = '0;
               slot_d   = '0;
            end else if (tick_q == TICK_LAST) begin
               // Slot boundary. The registered tx_start lands exactly
               // 1 + k*SLOT_TICKS cycles after the trigger cycle.
               tick_d = '0;
               if (tx_req) begin
                  start_d = 1'b1;
                  state_d = TX;
                  slot_d  = '0;
               end else if (slot_q == SLOT_LAST) begin
                  missed_d = 1'b1;
                  state_d  = IDLE;
                  slot_d   = '0;
               end else begin
                  slot_d = slot_q + SW'(1);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end

         TX: begin
            if (tx_done) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            tick_d  = '0;
            slot_d  = '0;
         end
      endcase
   end

   assign tx_start  = start_q;
   assign tx_missed = missed_q;
   assign busy      = (state_q != IDLE);
   assign slot_num  = slot_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_fdt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fdt_tx_scheduler
//
// Purpose:
//   Directed bench for fdt_tx_scheduler with the default parameters
//   (SLOT_TICKS=128, MAX_SLOTS=16). Each step() advances one rising edge and
//   then samples the outputs 1 ns later. Cycle offsets count the edges after
//   the cycle in which fdt_trigger was presented. An offset of 1 is the cycle
//   right after the trigger cycle.
// -----------------------------------------------------------------------------
module tb_fdt_tx_scheduler;

   localparam int ST_IDLE = 0;
   localparam int ST_RX   = 1;
   localparam int ST_WAIT = 2;
   localparam int ST_SLOT = 3;
   localparam int ST_TX   = 4;

   logic       clk;
   logic       rst_n;
   logic       pause_n_synchronised;
   logic       rx_eoc;
   logic       rx_error;
   logic       fdt_trigger;
   logic       tx_req;
   logic       tx_fixed_fdt;
   logic       tx_done;
   logic       tx_start;
   logic       tx_missed;
   logic       busy;
   logic [4:0] slot_num;
   logic [2:0] fsm_state;

   int n_cmp = 0;
   int n_err = 0;

   fdt_tx_scheduler #(
      .SLOT_TICKS(128),
      .MAX_SLOTS (16)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .pause_n_synchronised(pause_n_synchronised),
      .rx_eoc              (rx_eoc),
      .rx_error            (rx_error),
      .fdt_trigger         (fdt_trigger),
      .tx_req              (tx_req),
      .tx_fixed_fdt        (tx_fixed_fdt),
      .tx_done             (tx_done),
      .tx_start            (tx_start),
      .tx_missed           (tx_missed),
      .busy                (busy),
      .slot_num            (slot_num),
      .fsm_state           (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drives a PCD frame: a one-cycle pause, some bit time, then end of frame.
   task automatic enter_wait(input string tag);
      pause_n_synchronised = 1'b0;
      step();
      pause_n_synchronised = 1'b1;
      step();
      step();
      rx_eoc = 1'b1;
      step();
      rx_eoc = 1'b0;
      check_eq({tag, "_wait_state"}, 32'(fsm_state), ST_WAIT);
   endtask

   task automatic finish_tx(input string tag);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check_eq({tag, "_idle_after_done"}, 32'(busy), 0);
   endtask

   int off;
   int start_at;
   int missed_at;
   int n_start;

   initial begin
      rst_n                = 1'b0;
      pause_n_synchronised = 1'b1;
      rx_eoc               = 1'b0;
      rx_error             = 1'b0;
      fdt_trigger          = 1'b0;
      tx_req               = 1'b0;
      tx_fixed_fdt         = 1'b0;
      tx_done              = 1'b0;
      step();
      step();

      // reset state
      check_eq("rst_state", 32'(fsm_state), ST_IDLE);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_start", 32'(tx_start), 0);
      check_eq("rst_missed", 32'(tx_missed), 0);
      check_eq("rst_slot", 32'(slot_num), 0);
      rst_n = 1'b1;
      step();

      // IDLE ignores everything except a pause
      rx_eoc      = 1'b1;
      fdt_trigger = 1'b1;
      tx_req      = 1'b1;
      step();
      rx_eoc      = 1'b0;
      fdt_trigger = 1'b0;
      tx_req      = 1'b0;
      check_eq("idle_ignores", 32'(fsm_state), ST_IDLE);

      // immediate response at the trigger, start exactly one cycle later
      enter_wait("imm");
      tx_req      = 1'b1;
      fdt_trigger = 1'b1;
      check_eq("imm_no_early_start", 32'(tx_start), 0);
      step();
      fdt_trigger = 1'b0;
      check_eq("imm_start_t1", 32'(tx_start), 1);
      check_eq("imm_state_tx", 32'(fsm_state), ST_TX);
      tx_req = 1'b0;
      // TX ignores pause, frame pulses and further triggers
      pause_n_synchronised = 1'b0;
      rx_eoc               = 1'b1;
      rx_error             = 1'b1;
      fdt_trigger          = 1'b1;
      step();
      pause_n_synchronised = 1'b1;
      rx_eoc               = 1'b0;
      rx_error             = 1'b0;
      fdt_trigger          = 1'b0;
      check_eq("imm_start_one_cycle", 32'(tx_start), 0);
      check_eq("imm_tx_holds", 32'(fsm_state), ST_TX);
      check_eq("imm_busy", 32'(busy), 1);
      finish_tx("imm");

      // fixed FDT without data: missed at T+1, no start
      enter_wait("fix");
      tx_fixed_fdt = 1'b1;
      fdt_trigger  = 1'b1;
      step();
      fdt_trigger  = 1'b0;
      tx_fixed_fdt = 1'b0;
      check_eq("fix_missed_t1", 32'(tx_missed), 1);
      check_eq("fix_no_start", 32'(tx_start), 0);
      check_eq("fix_state_idle", 32'(fsm_state), ST_IDLE);
      step();
      check_eq("fix_missed_one_cycle", 32'(tx_missed), 0);

      // slot 1: data becomes ready in the boundary cycle 128, start at 129
      enter_wait("s1");
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      off = 1;
      check_eq("s1_state_slot", 32'(fsm_state), ST_SLOT);
      check_eq("s1_slot_num", 32'(slot_num), 1);
      start_at = 0;
      while (off < 400 && start_at == 0) begin
         if (off == 128) tx_req = 1'b1;
         step();
         off++;
         if (tx_start) start_at = off;
      end
      tx_req = 1'b0;
      check_eq("s1_start_at", 32'(start_at), 129);
      check_eq("s1_slot_num_tx", 32'(slot_num), 0);
      finish_tx("s1");

      // slot 2: data raised at T+200, start at T+257
      enter_wait("s2");
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      off      = 1;
      start_at = 0;
      n_start  = 0;
      while (off < 400) begin
         if (off == 200) tx_req = 1'b1;
         step();
         off++;
         if (off == 128) check_eq("s2_slot_at_128", 32'(slot_num), 1);
         if (off == 129) check_eq("s2_slot_at_129", 32'(slot_num), 2);
         if (off == 256) check_eq("s2_slot_at_256", 32'(slot_num), 2);
         if (off == 257) tx_req = 1'b0;
         if (tx_start) begin
            n_start++;
            if (start_at == 0) start_at = off;
         end
      end
      tx_req = 1'b0;
      check_eq("s2_start_at", 32'(start_at), 257);
      check_eq("s2_start_count", 32'(n_start), 1);
      check_eq("s2_busy_in_tx", 32'(busy), 1);
      finish_tx("s2");

      // never ready: missed after the last of 16 slots, at T+2049
      enter_wait("max");
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      off       = 1;
      missed_at = 0;
      n_start   = 0;
      while (off < 2200 && missed_at == 0) begin
         step();
         off++;
         if (off == 2048) check_eq("max_slot_16", 32'(slot_num), 16);
         if (tx_start) n_start++;
         if (tx_missed) missed_at = off;
      end
      check_eq("max_missed_at", 32'(missed_at), 2049);
      check_eq("max_no_start", 32'(n_start), 0);
      check_eq("max_state_idle", 32'(fsm_state), ST_IDLE);

      // pause during SLOT: missed next cycle, back to RX
      enter_wait("ps");
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      for (int i = 0; i < 10; i++) step();
      pause_n_synchronised = 1'b0;
      step();
      pause_n_synchronised = 1'b1;
      check_eq("ps_missed", 32'(tx_missed), 1);
      check_eq("ps_state_rx", 32'(fsm_state), ST_RX);
      check_eq("ps_slot_zero", 32'(slot_num), 0);

      // pause and trigger in the same WAIT_FDT cycle: pause wins, no start
      rx_eoc = 1'b1;
      step();
      rx_eoc = 1'b0;
      check_eq("pw_wait", 32'(fsm_state), ST_WAIT);
      tx_req               = 1'b1;
      fdt_trigger          = 1'b1;
      pause_n_synchronised = 1'b0;
      step();
      fdt_trigger          = 1'b0;
      pause_n_synchronised = 1'b1;
      check_eq("pw_state_rx", 32'(fsm_state), ST_RX);
      check_eq("pw_no_start", 32'(tx_start), 0);
      step();
      check_eq("pw_still_no_start", 32'(tx_start), 0);
      tx_req = 1'b0;

      // rx_eoc with rx_error: IDLE, later trigger ignored
      rx_eoc   = 1'b1;
      rx_error = 1'b1;
      step();
      rx_eoc   = 1'b0;
      rx_error = 1'b0;
      check_eq("err_state_idle", 32'(fsm_state), ST_IDLE);
      tx_req      = 1'b1;
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      tx_req      = 1'b0;
      check_eq("err_trig_ignored", 32'(tx_start), 0);
      check_eq("err_stays_idle", 32'(fsm_state), ST_IDLE);

      // reset during TX: everything clears next cycle
      enter_wait("rtx");
      tx_req      = 1'b1;
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      tx_req      = 1'b0;
      check_eq("rtx_in_tx", 32'(fsm_state), ST_TX);
      rst_n = 1'b0;
      step();
      check_eq("rtx_start", 32'(tx_start), 0);
      check_eq("rtx_missed", 32'(tx_missed), 0);
      check_eq("rtx_busy", 32'(busy), 0);
      check_eq("rtx_state", 32'(fsm_state), ST_IDLE);
      rst_n = 1'b1;
      step();

      // reset at the SLOT boundary: no start and no missed pulse
      enter_wait("rsl");
      fdt_trigger = 1'b1;
      step();
      fdt_trigger = 1'b0;
      for (int i = 1; i < 128; i++) step();
      tx_req = 1'b1;
      rst_n  = 1'b0;
      step();
      check_eq("rsl_no_start", 32'(tx_start), 0);
      check_eq("rsl_no_missed", 32'(tx_missed), 0);
      check_eq("rsl_slot_zero", 32'(slot_num), 0);
      tx_req = 1'b0;
      rst_n  = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
